fp_mul_div_seq: RTL

FP_MUL_DIV_SEQ -- requirements
Module: fp_mul_div_seq

---
 rtl/fp_mul_div_seq.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_mul_div_seq.sv
// Sequential IEEE-754-style multiply / divide unit.
// Shift-add multiply or restoring divide, then round-to-nearest-even.
module fp_mul_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   en,
    input  logic                   sel,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [EXP_W+MAN_W:0]   R,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   io_flag,
    output logic                   dz_flag,
    output logic                   of_flag,
    output logic                   uf_flag,
    output logic                   i_flag
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int P  = MAN_W + 1;
    localparam int EW = EXP_W + 3;
    localparam int CW = $clog2(P + 1) + 1;

    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE  = EW'(1);
    localparam logic signed [EW-1:0] ZERO = '0;
    localparam logic [CW-1:0]        LAST = CW'(P);
    localparam logic [CW-1:0]        RND1 = CW'(1);

    localparam logic [W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

    state_t state_q, state_d;

    logic                   op_q, op_d;
    logic                   sgn_q, sgn_d;
    logic                   spc_q, spc_d;
    logic [W-1:0]           spr_q, spr_d;
    logic [4:0]             spf_q, spf_d;
    logic signed [EW-1:0]   exp_q, exp_d;
    logic [2*P-1:0]         acc_q, acc_d;
    logic [2*P-1:0]         x_q, x_d;
    logic [P-1:0]           y_q, y_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [MAN_W-1:0]       m_q, m_d;
    logic signed [EW-1:0]   e_q, e_d;
    logic                   ix_q, ix_d;
    logic [W-1:0]           r_q, r_d;
    logic [4:0]             fl_q, fl_d;

    // operand field decode
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic [P-1:0]         ma, mb;
    logic signed [EW-1:0] ea_s, eb_s;
    logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic                 a_snan, b_snan, s_in, lt;

    assign ea     = a[W-2:MAN_W];
    assign eb     = b[W-2:MAN_W];
    assign fa     = a[MAN_W-1:0];
    assign fb     = b[MAN_W-1:0];
    assign ma     = {1'b1, fa};
    assign mb     = {1'b1, fb};
    assign ea_s   = {3'b000, ea};
    assign eb_s   = {3'b000, eb};
    assign a_nan  = (&ea) & (|fa);
    assign b_nan  = (&eb) & (|fb);
    assign a_inf  = (&ea) & ~(|fa);
    assign b_inf  = (&eb) & ~(|fb);
    assign a_zero = ~(|ea);
    assign b_zero = ~(|eb);
    assign a_snan = a_nan & ~fa[MAN_W-1];
    assign b_snan = b_nan & ~fb[MAN_W-1];
    assign s_in   = a[W-1] ^ b[W-1];
    assign lt     = ma < mb;

    // special-operand result, decided at capture time
    logic         spc_n;
    logic [W-1:0] spr_n;
    logic [4:0]   spf_n;
    logic [W-1:0] inf_n, zero_n;

    assign inf_n  = {s_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign zero_n = {s_in, {(W-1){1'b0}}};

    // classify NaN / infinity / zero operand combinations
    always_comb begin
        spc_n = 1'b1;
        spr_n = QNAN;
        spf_n = 5'b00000;
        if (a_nan | b_nan) begin
            spf_n = {a_snan | b_snan, 4'b0000};
        end else if (!sel) begin
            if ((a_inf & b_zero) | (a_zero & b_inf)) begin
                spf_n = 5'b10000;
            end else if (a_inf | b_inf) begin
                spr_n = inf_n;
            end else if (a_zero | b_zero) begin
                spr_n = zero_n;
            end else begin
                spc_n = 1'b0;
            end
        end else begin
            if ((a_zero & b_zero) | (a_inf & b_inf)) begin
                spf_n = 5'b10000;
            end else if (b_zero) begin
                spr_n = inf_n;
                spf_n = {1'b0, ~a_inf, 3'b000};
            end else if (a_inf) begin
                spr_n = inf_n;
            end else if (a_zero | b_inf) begin
                spr_n = zero_n;
            end else begin
                spc_n = 1'b0;
            end
        end
    end

    // normalise raw product / quotient and apply round-half-even
    logic [P-1:0]         man;
    logic                 g, st;
    logic signed [EW-1:0] e_n, e_r;
    logic [P:0]           m_sum;
    logic [MAN_W-1:0]     frac;

    always_comb begin
        if (op_q) begin
            man = acc_q[P:1];
            g   = acc_q[0];
            st  = |x_q;
            e_n = exp_q;
        end else if (acc_q[2*P-1]) begin
            man = acc_q[2*P-1:P];
            g   = acc_q[P-1];
            st  = |acc_q[P-2:0];
            e_n = exp_q + ONE;
        end else begin
            man = acc_q[2*P-2:P-1];
            g   = acc_q[P-2];
            st  = |acc_q[P-3:0];
            e_n = exp_q;
        end
        m_sum = {1'b0, man} + {{P{1'b0}}, g & (st | man[0])};
        frac  = m_sum[P] ? m_sum[MAN_W:1] : m_sum[MAN_W-1:0];
        e_r   = m_sum[P] ? e_n + ONE : e_n;
    end

    // datapath next-state: capture, iterate, round, publish
    logic           ge;
    logic [2*P-1:0] rem;

    always_comb begin
        op_d  = op_q;
        sgn_d = sgn_q;
        spc_d = spc_q;
        spr_d = spr_q;
        spf_d = spf_q;
        exp_d = exp_q;
        acc_d = acc_q;
        x_d   = x_q;
        y_d   = y_q;
        cnt_d = cnt_q;
        m_d   = m_q;
        e_d   = e_q;
        ix_d  = ix_q;
        r_d   = r_q;
        fl_d  = fl_q;
        ge    = x_q >= {{P{1'b0}}, y_q};
        rem   = ge ? x_q - {{P{1'b0}}, y_q} : x_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d  = sel;
                    sgn_d = s_in;
                    spc_d = spc_n;
                    spr_d = spr_n;
                    spf_d = spf_n;
                    acc_d = '0;
                    y_d   = mb;
                    cnt_d = '0;
                    if (sel) begin
                        x_d   = lt ? {{(P-1){1'b0}}, ma, 1'b0}
                                   : {{P{1'b0}}, ma};
                        exp_d = ea_s - eb_s + BIAS - (lt ? ONE : ZERO);
                    end else begin
                        x_d   = {{P{1'b0}}, ma};
                        exp_d = ea_s + eb_s - BIAS;
                    end
                end
            end
            CALC: begin
                cnt_d = (cnt_q == LAST) ? '0 : cnt_q + RND1;
                if (op_q) begin
                    acc_d = {acc_q[2*P-2:0], ge};
                    x_d   = {rem[2*P-2:0], 1'b0};
                end else begin
                    acc_d = y_q[0] ? acc_q + x_q : acc_q;
                    x_d   = {x_q[2*P-2:0], 1'b0};
                    y_d   = {1'b0, y_q[P-1:1]};
                end
            end
            ROUND: begin
                if (cnt_q == '0) begin
                    m_d   = frac;
                    e_d   = e_r;
                    ix_d  = g | st;
                    cnt_d = RND1;
                end else if (spc_q) begin
                    r_d  = spr_q;
                    fl_d = spf_q;
                end else if (e_q >= EMAX) begin
                    r_d  = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    fl_d = 5'b00101;
                end else if (e_q <= ZERO) begin
                    r_d  = {sgn_q, {(W-1){1'b0}}};
                    fl_d = 5'b00011;
                end else begin
                    r_d  = {sgn_q, e_q[EXP_W-1:0], m_q};
                    fl_d = {4'b0000, ix_q};
                end
            end
            DONE: begin
            end
        endcase
    end

    // datapath registers, frozen while en is low
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            op_q  <= 1'b0;
            sgn_q <= 1'b0;
            spc_q <= 1'b0;
            spr_q <= '0;
            spf_q <= '0;
            exp_q <= '0;
            acc_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            cnt_q <= '0;
            m_q   <= '0;
            e_q   <= '0;
            ix_q  <= 1'b0;
            r_q   <= '0;
            fl_q  <= '0;
        end else if (en) begin
            op_q  <= op_d;
            sgn_q <= sgn_d;
            spc_q <= spc_d;
            spr_q <= spr_d;
            spf_q <= spf_d;
            exp_q <= exp_d;
            acc_q <= acc_d;
            x_q   <= x_d;
            y_q   <= y_d;
            cnt_q <= cnt_d;
            m_q   <= m_d;
            e_q   <= e_d;
            ix_q  <= ix_d;
            r_q   <= r_d;
            fl_q  <= fl_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= IDLE;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    // FSM next state; ROUND spends two cycles (round, then range check)
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (in_valid) state_d = CALC;
            CALC:  if (cnt_q == LAST) state_d = ROUND;
            ROUND: if (cnt_q == RND1) state_d = DONE;
            DONE:  if (out_ready) state_d = IDLE;
        endcase
    end

    // FSM outputs and result ports
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        R         = r_q;
        io_flag   = fl_q[4];
        dz_flag   = fl_q[3];
        of_flag   = fl_q[2];
        uf_flag   = fl_q[1];
        i_flag    = fl_q[0];
    end

endmodule
